sms_card_trl: RTL and testbench

SMS_CARD_TRL -- requirements
Module: sms_card_trl

---
 rtl/sms_trl_pkg.sv | 15 +
 rtl/sms_trl_channel.sv | 134 +++++++++++++
 rtl/sms_card_trl.sv | 34 +++
 tb/tb_sms_card_trl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sms_trl_pkg.sv
// Shared types and constants for the open-collector bus receive channels.
package sms_trl_pkg;

    localparam int unsigned FILTER_LEN_DEF = 3;
    localparam int unsigned CNT_W          = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_STABLE_LO,
        ST_QUAL_RISE,
        ST_STABLE_HI,
        ST_QUAL_FALL
    } trl_state_e;

endpackage

// File: rtl/sms_trl_channel.sv
// One bus receive channel: pull-up resolution, two-flop synchronizer,
// qualify FSM with saturating counter, edge pulses and a sticky held flag.
module sms_trl_channel
    import sms_trl_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_bus,
    input  logic i_clear,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_held
);

    localparam logic [CNT_W-1:0] FILT = CNT_W'(FILTER_LEN);

    logic             w_res;
    logic             r_sync1, r_sync2;
    trl_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_level, w_level_nxt;
    logic             r_rise, w_rise_nxt;
    logic             r_fall, w_fall_nxt;
    logic             r_held, w_held_nxt;

    // A released line (z) reads as the pull-up level; an unknown level reads as driven low.
    always_comb begin
        if (i_bus === 1'b1)      w_res = 1'b1;
        else if (i_bus === 1'b0) w_res = 1'b0;
        else                     w_res = (i_bus !== 1'bx);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= w_res;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_STABLE_LO: if (r_sync2) begin
                if (FILTER_LEN == 1) begin
                    w_state_nxt = ST_STABLE_HI;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_QUAL_RISE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_QUAL_RISE: if (!r_sync2) begin
                w_state_nxt = ST_STABLE_LO;
                w_cnt_nxt   = '0;
            end else if (w_cnt_inc == FILT) begin
                w_state_nxt = ST_STABLE_HI;
                w_level_nxt = 1'b1;
                w_rise_nxt  = 1'b1;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = w_cnt_inc;
            end
            ST_STABLE_HI: if (!r_sync2) begin
                if (FILTER_LEN == 1) begin
                    w_state_nxt = ST_STABLE_LO;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_QUAL_FALL;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_QUAL_FALL: if (r_sync2) begin
                w_state_nxt = ST_STABLE_HI;
                w_cnt_nxt   = '0;
            end else if (w_cnt_inc == FILT) begin
                w_state_nxt = ST_STABLE_LO;
                w_level_nxt = 1'b0;
                w_fall_nxt  = 1'b1;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = w_cnt_inc;
            end
            default: begin
                w_state_nxt = ST_STABLE_HI;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Clear is ignored while rise is showing, and a new set always beats clear.
    assign w_held_nxt = w_rise_nxt | (r_held & ~(i_clear & ~r_rise));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_STABLE_HI;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_held  <= w_held_nxt;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_held  = r_held;

endmodule

// File: rtl/sms_card_trl.sv
// Multi-channel open-collector bus receiver card: one independent
// filtered channel per bus line.
module sms_card_trl
    import sms_trl_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] bus_in,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] held
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sms_trl_channel #(
            .FILTER_LEN (FILTER_LEN)
        ) u_channel (
            .clk     (clk),
            .reset_n (reset_n),
            .i_bus   (bus_in[g]),
            .i_clear (clear[g]),
            .o_level (level[g]),
            .o_rise  (rise[g]),
            .o_fall  (fall[g]),
            .o_held  (held[g])
        );
    end

endmodule

// File: tb/tb_sms_card_trl.sv
// Directed bench for sms_card_trl (4 channels, filter length 3); each bus
// line is pulled up and only ever driven low (or unknown) by the bench.
module tb_sms_card_trl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] clear;
    logic [3:0] r_low;
    logic [3:0] r_lowval;
    tri1  [3:0] w_bus;
    logic [3:0] level, rise, fall, held;

    int n_total = 0;
    int n_bad   = 0;

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign w_bus[i] = r_low[i] ? r_lowval[i] : 1'bz;
    end

    always #5 clk = ~clk;

    sms_card_trl #(
        .CHANNELS   (4),
        .FILTER_LEN (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_in  (w_bus),
        .clear   (clear),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .held    (held)
    );

    task automatic check(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {level, rise, fall, held};
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: level/rise/fall/held observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step_chk(input string tag, input logic [3:0] lv, input logic [3:0] r,
                            input logic [3:0] f, input logic [3:0] h);
        @(negedge clk);
        check(tag, {lv, r, f, h});
    endtask

    initial begin
        reset_n  = 1'b0;
        clear    = 4'h0;
        r_low    = 4'h0;
        r_lowval = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_state", {4'hF, 4'h0, 4'h0, 4'h0});
        reset_n = 1'b1;

        // All lines released: nothing may move.
        for (int k = 0; k < 20; k++) step_chk("idle", 4'hF, 4'h0, 4'h0, 4'h0);

        // Channel 0 driven low for 10 cycles: level falls after E4.
        r_low[0] = 1'b1;
        for (int k = 0; k < 4; k++) step_chk("ch0_qual_fall", 4'hF, 4'h0, 4'h0, 4'h0);
        step_chk("ch0_fall_pulse", 4'hE, 4'h0, 4'h1, 4'h0);
        for (int k = 0; k < 5; k++) step_chk("ch0_low_hold", 4'hE, 4'h0, 4'h0, 4'h0);
        r_low[0] = 1'b0;
        for (int k = 0; k < 4; k++) step_chk("ch0_qual_rise", 4'hE, 4'h0, 4'h0, 4'h0);
        step_chk("ch0_rise_pulse", 4'hF, 4'h1, 4'h0, 4'h1);
        step_chk("ch0_held", 4'hF, 4'h0, 4'h0, 4'h1);
        clear = 4'h1;
        step_chk("ch0_clear", 4'hF, 4'h0, 4'h0, 4'h0);
        clear = 4'h0;

        // Channel 1: 2-cycle glitch is rejected, 3-cycle low is accepted.
        r_low[1] = 1'b1;
        for (int k = 0; k < 2; k++) step_chk("ch1_glitch", 4'hF, 4'h0, 4'h0, 4'h0);
        r_low[1] = 1'b0;
        for (int k = 0; k < 6; k++) step_chk("ch1_glitch_reject", 4'hF, 4'h0, 4'h0, 4'h0);
        r_low[1] = 1'b1;
        for (int k = 0; k < 3; k++) step_chk("ch1_low3", 4'hF, 4'h0, 4'h0, 4'h0);
        r_low[1] = 1'b0;
        step_chk("ch1_before_e4", 4'hF, 4'h0, 4'h0, 4'h0);
        step_chk("ch1_fall_e4", 4'hD, 4'h0, 4'h2, 4'h0);
        for (int k = 0; k < 2; k++) step_chk("ch1_requal", 4'hD, 4'h0, 4'h0, 4'h0);
        step_chk("ch1_rise", 4'hF, 4'h2, 4'h0, 4'h2);
        clear = 4'h2;
        step_chk("ch1_clear_in_rise", 4'hF, 4'h0, 4'h0, 4'h2);
        step_chk("ch1_clear", 4'hF, 4'h0, 4'h0, 4'h0);
        clear = 4'h0;

        // Channel 2: held set on rise, clear during rise ignored, clear after wins.
        r_low[2] = 1'b1;
        for (int k = 0; k < 4; k++) step_chk("ch2_qual_fall", 4'hF, 4'h0, 4'h0, 4'h0);
        step_chk("ch2_fall", 4'hB, 4'h0, 4'h4, 4'h0);
        r_low[2] = 1'b0;
        for (int k = 0; k < 4; k++) step_chk("ch2_qual_rise", 4'hB, 4'h0, 4'h0, 4'h0);
        step_chk("ch2_rise", 4'hF, 4'h4, 4'h0, 4'h4);
        clear = 4'h4;
        step_chk("ch2_clear_with_rise", 4'hF, 4'h0, 4'h0, 4'h4);
        step_chk("ch2_clear_later", 4'hF, 4'h0, 4'h0, 4'h0);
        clear = 4'h0;

        // Channel 3: reset mid-qualification abandons the pending fall.
        r_low[3] = 1'b1;
        for (int k = 0; k < 2; k++) step_chk("ch3_pre_reset", 4'hF, 4'h0, 4'h0, 4'h0);
        reset_n  = 1'b0;
        r_low[3] = 1'b0;
        step_chk("ch3_in_reset", 4'hF, 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) step_chk("ch3_after_reset", 4'hF, 4'h0, 4'h0, 4'h0);

        // Channel 0 driven unknown: reads as low.
        r_lowval[0] = 1'bx;
        r_low[0]    = 1'b1;
        for (int k = 0; k < 4; k++) step_chk("ch0x_qual", 4'hF, 4'h0, 4'h0, 4'h0);
        step_chk("ch0x_fall", 4'hE, 4'h0, 4'h1, 4'h0);
        step_chk("ch0x_low", 4'hE, 4'h0, 4'h0, 4'h0);
        r_low[0]    = 1'b0;
        r_lowval[0] = 1'b0;
        for (int k = 0; k < 4; k++) step_chk("ch0x_qual_rise", 4'hE, 4'h0, 4'h0, 4'h0);
        step_chk("ch0x_rise", 4'hF, 4'h1, 4'h0, 4'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
